// File: rtl/sdp_x_chn_in_rsci_skid.sv
// Input-channel skid buffer: DEPTH-entry circular FIFO between an upstream
// valid/ready producer and a core that reads with oswt/wen/wten handshaking.
module sdp_x_chn_in_rsci_skid #(
  parameter int WIDTH = 512,
  parameter int DEPTH = 2,
  parameter int CNT_W = 2
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic [WIDTH-1:0] chn_in_rsc_z,
  input  logic             chn_in_rsc_vz,
  output logic             chn_in_rsc_lz,
  input  logic             core_wen,
  input  logic             core_wten,
  input  logic             chn_in_rsci_oswt,
  input  logic             chn_in_rsci_flush,
  output logic             chn_in_rsci_bawt,
  output logic             chn_in_rsci_wen_comp,
  output logic [WIDTH-1:0] chn_in_rsci_d_mxwt,
  output logic [CNT_W-1:0] chn_in_rsci_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] next_count;
  logic             lz_q;
  logic             bawt;
  logic             push;
  logic             pop;

  assign bawt = (count_q != '0);
  assign push = chn_in_rsc_vz & lz_q;
  assign pop  = chn_in_rsci_oswt & core_wen & ~core_wten & bawt;

  always_comb begin
    next_count = count_q;
    if (chn_in_rsci_flush)
      next_count = '0;
    else if (push && !pop)
      next_count = count_q + CNT_W'(1);
    else if (pop && !push)
      next_count = count_q - CNT_W'(1);
  end

  // Ready is registered from next occupancy so the upstream never sees a
  // combinational path from the core-side handshake.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      count_q <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      lz_q    <= 1'b0;
    end else begin
      count_q <= next_count;
      lz_q    <= (next_count < FULL);
      if (chn_in_rsci_flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (push) mem[wr_ptr] <= chn_in_rsc_z;
  end

  assign chn_in_rsc_lz        = lz_q;
  assign chn_in_rsci_bawt     = bawt;
  assign chn_in_rsci_wen_comp = ~chn_in_rsci_oswt | bawt;
  assign chn_in_rsci_d_mxwt   = bawt ? mem[rd_ptr] : '0;
  assign chn_in_rsci_count    = count_q;

endmodule

// File: tb/tb_sdp_x_chn_in_rsci_skid.sv
// Bench for sdp_x_chn_in_rsci_skid: directed scenarios plus random traffic,
// checked every cycle against a queue-based model of the skid buffer.
module tb_sdp_x_chn_in_rsci_skid;
  localparam int W     = 512;
  localparam int DEPTH = 2;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rstn;
  logic [W-1:0]     z;
  logic             vz, lz;
  logic             wen, wten, oswt, flush;
  logic             bawt, wen_comp;
  logic [W-1:0]     d;
  logic [CNT_W-1:0] count;

  int vectors = 0;
  int errors  = 0;

  logic [W-1:0] model_q[$];
  logic         model_lz = 1'b0;

  sdp_x_chn_in_rsci_skid #(.WIDTH(W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .nvdla_core_clk       (clk),
    .nvdla_core_rstn      (rstn),
    .chn_in_rsc_z         (z),
    .chn_in_rsc_vz        (vz),
    .chn_in_rsc_lz        (lz),
    .core_wen             (wen),
    .core_wten            (wten),
    .chn_in_rsci_oswt     (oswt),
    .chn_in_rsci_flush    (flush),
    .chn_in_rsci_bawt     (bawt),
    .chn_in_rsci_wen_comp (wen_comp),
    .chn_in_rsci_d_mxwt   (d),
    .chn_in_rsci_count    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // Monitor/model: mid-cycle, compare DUT against the queue, then advance the
  // queue according to what the coming rising edge should do.
  always @(negedge clk) begin
    logic [W-1:0] head;
    logic do_push, do_pop;
    if (!rstn) begin
      model_q.delete();
      model_lz = 1'b0;
    end
    head = (model_q.size() != 0) ? model_q[0] : '0;
    chk("count",    W'(count),    W'(model_q.size()));
    chk("lz",       W'(lz),       W'(model_lz));
    chk("bawt",     W'(bawt),     W'(model_q.size() != 0));
    chk("wen_comp", W'(wen_comp), W'(!oswt || model_q.size() != 0));
    chk("d_mxwt",   d,            head);
    if (rstn) begin
      do_push = vz && model_lz;
      do_pop  = oswt && wen && !wten && model_q.size() != 0;
      if (flush) begin
        model_q.delete();
      end else begin
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back(z);
      end
      model_lz = (model_q.size() < DEPTH);
    end
  end

  task automatic step(input logic v, input logic [W-1:0] dat, input logic o,
                      input logic we, input logic wt, input logic fl);
    vz = v; z = dat; oswt = o; wen = we; wten = wt; flush = fl;
    @(posedge clk);
    #2;
  endtask

  function automatic logic [W-1:0] rnd();
    logic [W-1:0] r;
    r = '0;
    for (int i = 0; i < W / 32; i++) r = {r[W-33:0], 32'($urandom)};
    return r;
  endfunction

  initial begin
    rstn = 1'b0; vz = 1'b0; z = '0; oswt = 1'b0; wen = 1'b1; wten = 1'b0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #2 rstn = 1'b1;
    step(0, '0, 0, 1, 0, 0);

    // Fill to DEPTH with no pop
    step(1, W'(32'hA), 0, 1, 0, 0);
    step(1, W'(32'hB), 0, 1, 0, 0);
    chk("full_count", W'(count), W'(2));
    chk("full_lz",    W'(lz),    W'(0));
    chk("full_head",  d,         W'(32'hA));

    // Held valid while full, then a pop frees a slot
    step(1, W'(32'hC), 0, 1, 0, 0);
    step(1, W'(32'hC), 1, 1, 0, 0);
    chk("after_pop_head", d,  W'(32'hB));
    chk("after_pop_lz",   W'(lz), W'(1));
    step(1, W'(32'hC), 1, 1, 0, 0);
    chk("c_head", d, W'(32'hC));
    step(0, '0, 1, 1, 0, 0);

    // Push+pop at count=1 across pointer wrap
    step(1, W'(32'h10), 0, 1, 0, 0);
    for (int i = 1; i <= 8; i++) step(1, W'(32'h10 + i), 1, 1, 0, 0);
    chk("pp_count", W'(count), W'(1));
    chk("pp_head",  d,         W'(32'h18));

    // Pop request while empty
    step(0, '0, 1, 1, 0, 0);
    chk("empty_wen_comp", W'(wen_comp), W'(0));
    chk("empty_d",        d,            '0);
    step(1, W'(32'h5), 1, 1, 0, 0);
    chk("first_wen_comp", W'(wen_comp), W'(1));
    chk("first_d",        d,            W'(32'h5));

    // Pop blocked by wten / !wen, then flush overriding a push
    step(0, '0, 1, 1, 1, 0);
    step(0, '0, 1, 0, 0, 0);
    chk("blocked_count", W'(count), W'(1));
    step(1, W'(32'h7), 0, 1, 0, 1);
    chk("flush_count", W'(count), W'(0));
    chk("flush_lz",    W'(lz),    W'(1));

    // Asynchronous reset mid-stream at count=2
    step(1, W'(32'h21), 0, 1, 0, 0);
    step(1, W'(32'h22), 0, 1, 0, 0);
    vz = 1'b0; oswt = 1'b1;
    #1 rstn = 1'b0;
    #1;
    chk("rst_count",    W'(count),    '0);
    chk("rst_lz",       W'(lz),       '0);
    chk("rst_bawt",     W'(bawt),     '0);
    chk("rst_d",        d,            '0);
    chk("rst_wen_comp", W'(wen_comp), '0);
    @(posedge clk); #2 rstn = 1'b1;
    step(1, W'(32'h31), 0, 1, 0, 0);
    chk("rel_lz", W'(lz), W'(1));
    step(1, W'(32'h31), 0, 1, 0, 0);
    step(1, W'(32'h32), 1, 1, 0, 0);
    step(0, '0, 1, 1, 0, 0);
    step(0, '0, 1, 1, 0, 0);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(1'($urandom_range(0, 3) != 0), rnd(), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 5) != 0), 1'($urandom_range(0, 5) == 0),
           1'($urandom_range(0, 49) == 0));
    end
    step(0, '0, 0, 1, 0, 0);
    @(negedge clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule

// File: doc/sdp_x_chn_in_rsci_skid.md
SDP_X_CHN_IN_RSCI_SKID -- requirements
Module: sdp_x_chn_in_rsci_skid

Interface
REQ-001 SHALL have parameter WIDTH, default 512: payload width in bits, allowed range 1..1024.
REQ-002 SHALL have parameter DEPTH, default 2: skid buffer entries, power of two, allowed range 2..16.
REQ-003 SHALL have parameter CNT_W, default 2: occupancy width, equal to clog2(DEPTH+1).
REQ-004 SHALL have port nvdla_core_clk  input  1  core clock; all state updates on its rising edge.
REQ-005 SHALL have port nvdla_core_rstn  input  1  reset; asynchronous, active-low.
REQ-006 SHALL have port chn_in_rsc_z  input  WIDTH  upstream payload.
REQ-007 SHALL have port chn_in_rsc_vz  input  1  upstream valid.
REQ-008 SHALL have port chn_in_rsc_lz  output  1  upstream ready; a transfer occurs when vz and lz are both high.
REQ-009 SHALL have port core_wen  input  1  core enable; when low, no pop.
REQ-010 SHALL have port core_wten  input  1  core wait-state indicator; when high, no pop.
REQ-011 SHALL have port chn_in_rsci_oswt  input  1  core requests a read this cycle.
REQ-012 SHALL have port chn_in_rsci_flush  input  1  synchronous clear of buffer contents.
REQ-013 SHALL have port chn_in_rsci_bawt  output  1  head data available (buffer not empty).
REQ-014 SHALL have port chn_in_rsci_wen_comp  output  1  core may proceed: high when oswt is low or bawt is high.
REQ-015 SHALL have port chn_in_rsci_d_mxwt  output  WIDTH  head-of-buffer payload.
REQ-016 SHALL have port chn_in_rsci_count  output  CNT_W  current occupancy, 0..DEPTH.

Function
REQ-017 SHALL implement a DEPTH-entry circular FIFO with write pointer, read pointer and occupancy count; pointers SHALL wrap modulo DEPTH.
REQ-018 Push SHALL occur when vz is high and lz is high; the payload is written at the write pointer and count is incremented.
REQ-019 Pop SHALL occur when oswt, core_wen and bawt are high and core_wten is low; the read pointer advances and count is decremented.
REQ-020 When push and pop occur in the same cycle, count SHALL be unchanged and both pointers SHALL advance.
REQ-021 lz SHALL be a register updated every cycle to (next_count < DEPTH); it SHALL have no combinational path from any core-side input.
REQ-022 When count is DEPTH, lz SHALL be low even if a pop occurs that cycle; lz SHALL rise on the cycle after the pop.
REQ-023 bawt SHALL equal (count != 0); d_mxwt SHALL show-ahead the entry at the read pointer, and SHALL be all-zero when count is 0.
REQ-024 Latency: a payload pushed in cycle N SHALL be visible on d_mxwt with bawt high in cycle N+1; there SHALL be no same-cycle bypass.
REQ-025 Ordering SHALL be strict FIFO; no payload SHALL be dropped or duplicated.
REQ-026 flush SHALL set count and both pointers to 0 at the next edge and SHALL override any push or pop in that cycle; lz SHALL be 1 on the following cycle.
REQ-027 count SHALL never exceed DEPTH or go below 0; a pop request while empty SHALL be a no-op, with wen_comp low while oswt is high.

Reset
REQ-028 While nvdla_core_rstn is low: count=0, pointers=0, lz=0, bawt=0, d_mxwt=0, wen_comp equal to the inverse of oswt.
REQ-029 lz SHALL be 1 on the first rising edge after reset deassertion; storage contents SHALL need no reset.
REQ-030 Reset asserted mid-operation SHALL discard all buffered entries immediately (asynchronously), independent of the clock.

Verification
REQ-031 DEPTH=2, WIDTH=512: push 0xA then 0xB with no pop -> count=2, lz=0 one cycle after the second push; d_mxwt=0xA.
REQ-032 Buffer full with vz held high, then one pop -> d_mxwt=0xB, lz=1 on the next cycle; a third payload 0xC is accepted one cycle later, and order is A,B,C.
REQ-033 Simultaneous push and pop at count=1 -> count stays 1 and the head advances; repeat for 8 cycles with an incrementing payload -> no loss and no reorder across pointer wrap.
REQ-034 oswt=1 with count=0 -> wen_comp=0, bawt=0, d_mxwt=0; push 0x5 -> next cycle wen_comp=1 and d_mxwt=0x5.
REQ-035 core_wten=1 or core_wen=0 with oswt=1 and count=1 -> no pop and count stays 1; flush asserted at the same time as a push -> count=0 and lz=1 on the next cycle.
REQ-036 rstn pulsed low asynchronously mid-stream at count=2 -> outputs take their reset values immediately; after release, lz=1 and the first pushed payload appears first.
